// File: rtl/timer_dev_if.sv
// Register-bus port of the timer: word select, qualified write strobe, write/read data and IRQ.
interface timer_dev_if;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] din;
    logic [31:0] dout;
    logic        irq;

    modport master (output addr, we, din, input dout, irq);
    modport slave  (input addr, we, din, output dout, irq);
endinterface

// File: rtl/timer_dev.sv
// Memory-mapped down-counter with one-shot / auto-reload modes and a maskable interrupt.
module timer_dev (
    input  logic        clk,
    input  logic        reset,
    timer_dev_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

    state_t      state, state_nxt;
    logic        ctrl_en, ctrl_im;
    logic [1:0]  ctrl_mode;
    logic [31:0] preset, count;
    logic        irq_flag;

    logic wr_ctrl, wr_preset, disabled, auto_mode;
    logic load_cnt, dec_cnt, zero_cnt, flag_set, flag_clr, hw_dis;

    assign wr_ctrl   = bus.we && (bus.addr == 2'd0);
    assign wr_preset = bus.we && (bus.addr == 2'd1);
    // A disabling CTRL write takes effect on the same edge it lands, outside IDLE.
    assign disabled  = ~ctrl_en | (wr_ctrl & ~bus.din[0]);
    assign auto_mode = (ctrl_mode == 2'b01);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ctrl_en) state_nxt = LOAD;
            LOAD:    state_nxt = disabled ? IDLE : CNT;
            CNT: begin
                if (disabled)          state_nxt = IDLE;
                else if (count <= 32'd1) state_nxt = INT;
            end
            INT:     state_nxt = (!disabled && auto_mode) ? LOAD : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        load_cnt = 1'b0;
        dec_cnt  = 1'b0;
        zero_cnt = 1'b0;
        flag_set = 1'b0;
        flag_clr = 1'b0;
        hw_dis   = 1'b0;
        case (state)
            LOAD: load_cnt = ~disabled;
            CNT: begin
                if (!disabled) begin
                    if (count > 32'd1) dec_cnt = 1'b1;
                    else begin
                        zero_cnt = 1'b1;
                        flag_set = 1'b1;
                    end
                end
            end
            INT: begin
                if (auto_mode) flag_clr = 1'b1;
                else           hw_dis   = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        bus.dout = 32'd0;
        case (bus.addr)
            2'd0:    bus.dout = {28'd0, ctrl_im, ctrl_mode, ctrl_en};
            2'd1:    bus.dout = preset;
            2'd2:    bus.dout = count;
            default: bus.dout = 32'd0;
        endcase
    end

    assign bus.irq = irq_flag & ctrl_im;

    // Software CTRL write outranks the hardware Enable clear in one-shot INT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_en   <= 1'b0;
            ctrl_mode <= 2'b00;
            ctrl_im   <= 1'b0;
        end else if (wr_ctrl) begin
            ctrl_en   <= bus.din[0];
            ctrl_mode <= bus.din[2:1];
            ctrl_im   <= bus.din[3];
        end else if (hw_dis) begin
            ctrl_en   <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)          preset <= 32'd0;
        else if (wr_preset) preset <= bus.din;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)         count <= 32'd0;
        else if (load_cnt) count <= preset;
        else if (dec_cnt)  count <= count - 32'd1;
        else if (zero_cnt) count <= 32'd0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                      irq_flag <= 1'b0;
        else if (wr_ctrl || wr_preset)  irq_flag <= 1'b0;
        else if (flag_set)              irq_flag <= 1'b1;
        else if (flag_clr)              irq_flag <= 1'b0;
    end
endmodule
